// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer between the MEM
// stage and the 512-byte data RAM. Checks alignment, holds the RAM inputs
// stable for a fixed access window, then returns a one-cycle response.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_se,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_enable,
    output logic              ram_rw,
    output logic              ram_se,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic [1:0]        ram_size,
    input  logic [31:0]       ram_dout
);

    localparam int unsigned      CNT_W     = 3;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hold_write;

    logic             accept_c;
    logic             misaligned_c;
    logic             last_c;

    logic             ram_enable_nxt;
    logic             ram_rw_nxt;
    logic             resp_valid_nxt;
    logic             req_ready_nxt;

    // Request acceptance, alignment check and end-of-window detect.
    always_comb begin
        accept_c     = (state == ST_IDLE) && req_valid;
        misaligned_c = ((req_size == 2'b01) && req_addr[0]) ||
                       (req_size[1] && (req_addr[1:0] != 2'b00));
        last_c       = (state == ST_ACCESS) && (cnt == WAIT_LAST);
    end

    // Next-state, window counter and next values of the registered controls.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        ram_enable_nxt = 1'b0;
        ram_rw_nxt     = 1'b0;
        resp_valid_nxt = 1'b0;
        req_ready_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (req_valid) begin
                    state_nxt = misaligned_c ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (last_c) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Write strobe only inside the window so the RAM never sees a stray write.
        ram_enable_nxt = (state_nxt == ST_ACCESS);
        ram_rw_nxt     = (state_nxt == ST_ACCESS) && (accept_c ? req_write : hold_write);
        resp_valid_nxt = (state_nxt == ST_RESP);
        req_ready_nxt  = (state_nxt == ST_IDLE);
    end

    // State, counter and control outputs; reset drops ram_enable immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ram_enable <= 1'b0;
            ram_rw     <= 1'b0;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ram_enable <= ram_enable_nxt;
            ram_rw     <= ram_rw_nxt;
            resp_valid <= resp_valid_nxt;
            req_ready  <= req_ready_nxt;
        end
    end

    // Request holding registers (they also drive the RAM) and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_write <= 1'b0;
            ram_se     <= 1'b0;
            ram_size   <= 2'b00;
            ram_addr   <= '0;
            ram_din    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept_c) begin
            hold_write <= req_write;
            ram_se     <= req_se;
            ram_size   <= req_size;
            ram_addr   <= req_addr;
            ram_din    <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= misaligned_c;
        end else if (last_c) begin
            resp_rdata <= hold_write ? 32'h0 : ram_dout;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (default window and a 4-cycle
// window), each attached to a byte-wide RAM model; expected responses come
// from a separate reference memory and are queued per request.
module tb_mem_access_ctrl;

    localparam int unsigned AW   = 9;
    localparam int          W_A  = 1;
    localparam int          W_B  = 3;
    localparam int          KMAX = 2 * W_B + 7;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        en;
        logic [7:0]  lat;
    } exp_t;

    typedef struct packed {
        logic          w;
        logic [1:0]    sz;
        logic          se;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_init;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic          a_req_valid, a_req_ready, a_req_write, a_req_se;
    logic [1:0]    a_req_size;
    logic [AW-1:0] a_req_addr;
    logic [31:0]   a_req_wdata;
    logic          a_resp_valid, a_resp_err;
    logic [31:0]   a_resp_rdata;
    logic          a_ram_enable, a_ram_rw, a_ram_se;
    logic [AW-1:0] a_ram_addr;
    logic [31:0]   a_ram_din, a_ram_dout;
    logic [1:0]    a_ram_size;

    logic          b_req_valid, b_req_ready, b_req_write, b_req_se;
    logic [1:0]    b_req_size;
    logic [AW-1:0] b_req_addr;
    logic [31:0]   b_req_wdata;
    logic          b_resp_valid, b_resp_err;
    logic [31:0]   b_resp_rdata;
    logic          b_ram_enable, b_ram_rw, b_ram_se;
    logic [AW-1:0] b_ram_addr;
    logic [31:0]   b_ram_din, b_ram_dout;
    logic [1:0]    b_ram_size;

    logic [7:0] mem_a   [512];
    logic [7:0] mem_b   [512];
    logic [7:0] exp_mem [512];

    exp_t sb_a [$];
    exp_t sb_b [$];

    mem_access_ctrl #(.WAIT_CYCLES(W_A), .ADDR_W(AW)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_size(a_req_size), .req_se(a_req_se), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .ram_enable(a_ram_enable), .ram_rw(a_ram_rw), .ram_se(a_ram_se), .ram_addr(a_ram_addr),
        .ram_din(a_ram_din), .ram_size(a_ram_size), .ram_dout(a_ram_dout)
    );

    mem_access_ctrl #(.WAIT_CYCLES(W_B), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_size(b_req_size), .req_se(b_req_se), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .ram_enable(b_ram_enable), .ram_rw(b_ram_rw), .ram_se(b_ram_se), .ram_addr(b_ram_addr),
        .ram_din(b_ram_din), .ram_size(b_ram_size), .ram_dout(b_ram_dout)
    );

    // Lane select and extension as performed by the data RAM.
    function automatic logic [31:0] lane(input logic [31:0] raw, input logic [1:0] size, input logic se);
        case (size)
            2'b00:   return se ? {{24{raw[7]}}, raw[7:0]}   : {24'h0, raw[7:0]};
            2'b01:   return se ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [31:0] ref_raw(input logic [AW-1:0] addr);
        logic [AW-1:0] i1, i2, i3;
        i1 = addr + 9'd1;
        i2 = addr + 9'd2;
        i3 = addr + 9'd3;
        return {exp_mem[i3], exp_mem[i2], exp_mem[i1], exp_mem[addr]};
    endfunction

    function automatic void ref_write(input logic [AW-1:0] addr, input logic [1:0] size, input logic [31:0] wd);
        logic [AW-1:0] i1, i2, i3;
        i1 = addr + 9'd1;
        i2 = addr + 9'd2;
        i3 = addr + 9'd3;
        exp_mem[addr] = wd[7:0];
        if (size != 2'b00) exp_mem[i1] = wd[15:8];
        if (size[1]) begin
            exp_mem[i2] = wd[23:16];
            exp_mem[i3] = wd[31:24];
        end
    endfunction

    // RAM models: combinational read, write on clock while enabled for write.
    logic [AW-1:0] a_i1, a_i2, a_i3, b_i1, b_i2, b_i3;
    logic [31:0]   a_raw, b_raw;

    always_comb begin
        a_i1 = a_ram_addr + 9'd1;
        a_i2 = a_ram_addr + 9'd2;
        a_i3 = a_ram_addr + 9'd3;
        b_i1 = b_ram_addr + 9'd1;
        b_i2 = b_ram_addr + 9'd2;
        b_i3 = b_ram_addr + 9'd3;
        a_raw = {mem_a[a_i3], mem_a[a_i2], mem_a[a_i1], mem_a[a_ram_addr]};
        b_raw = {mem_b[b_i3], mem_b[b_i2], mem_b[b_i1], mem_b[b_ram_addr]};
        a_ram_dout = (a_ram_enable && !a_ram_rw) ? lane(a_raw, a_ram_size, a_ram_se) : 32'h0;
        b_ram_dout = (b_ram_enable && !b_ram_rw) ? lane(b_raw, b_ram_size, b_ram_se) : 32'h0;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= 8'h00;
            end
            mem_b[9'h084] <= 8'h44;
            mem_b[9'h085] <= 8'h33;
            mem_b[9'h086] <= 8'h22;
            mem_b[9'h087] <= 8'h11;
        end else begin
            if (a_ram_enable && a_ram_rw) begin
                mem_a[a_ram_addr] <= a_ram_din[7:0];
                if (a_ram_size != 2'b00) mem_a[a_i1] <= a_ram_din[15:8];
                if (a_ram_size[1]) begin
                    mem_a[a_i2] <= a_ram_din[23:16];
                    mem_a[a_i3] <= a_ram_din[31:24];
                end
            end
            if (b_ram_enable && b_ram_rw) begin
                mem_b[b_ram_addr] <= b_ram_din[7:0];
                if (b_ram_size != 2'b00) mem_b[b_i1] <= b_ram_din[15:8];
                if (b_ram_size[1]) begin
                    mem_b[b_i2] <= b_ram_din[23:16];
                    mem_b[b_i3] <= b_ram_din[31:24];
                end
            end
        end
    end

    // Queue the expected response, issue one request on dut_a and observe it.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic se,
                          input logic [AW-1:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output logic [7:0] lat,
                          output logic en_seen, output logic rv_after);
        logic mis;
        exp_t e;
        int   guard;
        mis     = ((sz == 2'b01) && addr[0]) || (sz[1] && (addr[1:0] != 2'b00));
        e.err   = mis;
        e.en    = !mis;
        e.lat   = mis ? 8'd1 : 8'(W_A + 2);
        e.rdata = (mis || w) ? 32'h0 : lane(ref_raw(addr), sz, se);
        if (!mis && w) ref_write(addr, sz, wd);
        sb_a.push_back(e);

        guard = 0;
        @(negedge clk);
        while (!a_req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        a_req_valid = 1'b1;
        a_req_write = w;
        a_req_size  = sz;
        a_req_se    = se;
        a_req_addr  = addr;
        a_req_wdata = wd;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        lat     = 8'd1;
        en_seen = a_ram_enable;
        while (!a_resp_valid && lat < 8'd40) begin
            @(posedge clk);
            #1;
            lat++;
            en_seen = en_seen | a_ram_enable;
        end
        rd = a_resp_rdata;
        er = a_resp_err;
        @(posedge clk);
        #1;
        rv_after = a_resp_valid;
    endtask

    task automatic test_reset();
        logic [79:0] obs;
        logic        rv_seen;
        repeat (3) @(posedge clk);
        #1;
        obs = {a_resp_valid, a_resp_err, a_ram_enable, a_ram_rw, a_ram_se, a_ram_size,
               a_ram_addr, a_ram_din, a_resp_rdata};
        checks++;
        if (obs !== 80'h0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_a: got outputs=%h ready=%b, exp outputs=0 ready=1", obs, a_req_ready);
        end
        obs = {b_resp_valid, b_resp_err, b_ram_enable, b_ram_rw, b_ram_se, b_ram_size,
               b_ram_addr, b_ram_din, b_resp_rdata};
        checks++;
        if (obs !== 80'h0 || b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_b: got outputs=%h ready=%b, exp outputs=0 ready=1", obs, b_req_ready);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        mem_init = 1'b0;

        // Abort a store in the middle of its window.
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_write = 1'b1;
        a_req_size  = 2'b10;
        a_req_se    = 1'b1;
        a_req_addr  = 9'h100;
        a_req_wdata = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        checks++;
        if (a_ram_enable !== 1'b1 || a_ram_rw !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got en=%b rw=%b, exp en=1 rw=1", a_ram_enable, a_ram_rw);
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = {a_resp_valid, a_resp_err, a_ram_enable, a_ram_rw, a_ram_se, a_ram_size,
               a_ram_addr, a_ram_din, a_resp_rdata};
        checks++;
        if (obs !== 80'h0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset: got outputs=%h ready=%b, exp outputs=0 ready=1", obs, a_req_ready);
        end
        rv_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            rv_seen = rv_seen | a_resp_valid | a_ram_enable;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            rv_seen = rv_seen | a_resp_valid | a_ram_enable;
        end
        checks++;
        if (rv_seen !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_quiet: got resp_or_en=%b ready=%b, exp 0 and 1", rv_seen, a_req_ready);
        end
    endtask

    task automatic test_word_roundtrip();
        req_t tbl [2];
        logic [31:0] rd;
        logic er, en, rva;
        logic [7:0] lat;
        exp_t e;
        tbl[0] = '{w: 1'b1, sz: 2'b10, se: 1'b0, addr: 9'h010, wd: 32'hDEADBEEF};
        tbl[1] = '{w: 1'b0, sz: 2'b10, se: 1'b0, addr: 9'h010, wd: 32'h0};
        for (int i = 0; i < 2; i++) begin
            do_req(tbl[i].w, tbl[i].sz, tbl[i].se, tbl[i].addr, tbl[i].wd, rd, er, lat, en, rva);
            e = sb_a.pop_front();
            checks++;
            if ({rd, er} !== {e.rdata, e.err}) begin
                errors++;
                $display("FAIL word_rt[%0d] data: got rdata=%h err=%b, exp rdata=%h err=%b", i, rd, er, e.rdata, e.err);
            end
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL word_rt[%0d] latency: got %0d, exp %0d", i, lat, e.lat);
            end
            checks++;
            if (en !== e.en || rva !== 1'b0) begin
                errors++;
                $display("FAIL word_rt[%0d] enable/pulse: got en=%b next=%b, exp en=%b next=0", i, en, rva, e.en);
            end
        end
    endtask

    task automatic test_byte_sign_ext();
        req_t tbl [3];
        logic [31:0] rd;
        logic er, en, rva;
        logic [7:0] lat;
        exp_t e;
        tbl[0] = '{w: 1'b1, sz: 2'b00, se: 1'b0, addr: 9'h021, wd: 32'h00000080};
        tbl[1] = '{w: 1'b0, sz: 2'b00, se: 1'b1, addr: 9'h021, wd: 32'h0};
        tbl[2] = '{w: 1'b0, sz: 2'b00, se: 1'b0, addr: 9'h021, wd: 32'h0};
        for (int i = 0; i < 3; i++) begin
            do_req(tbl[i].w, tbl[i].sz, tbl[i].se, tbl[i].addr, tbl[i].wd, rd, er, lat, en, rva);
            e = sb_a.pop_front();
            checks++;
            if ({rd, er} !== {e.rdata, e.err}) begin
                errors++;
                $display("FAIL byte_se[%0d] data: got rdata=%h err=%b, exp rdata=%h err=%b", i, rd, er, e.rdata, e.err);
            end
            checks++;
            if (lat !== e.lat || en !== e.en || rva !== 1'b0) begin
                errors++;
                $display("FAIL byte_se[%0d] timing: got lat=%0d en=%b next=%b, exp lat=%0d en=%b next=0", i, lat, en, rva, e.lat, e.en);
            end
        end
    endtask

    task automatic test_halfword_lanes();
        req_t tbl [3];
        logic [31:0] rd;
        logic er, en, rva;
        logic [7:0] lat;
        exp_t e;
        tbl[0] = '{w: 1'b1, sz: 2'b10, se: 1'b0, addr: 9'h040, wd: 32'h1234ABCD};
        tbl[1] = '{w: 1'b0, sz: 2'b01, se: 1'b1, addr: 9'h042, wd: 32'h0};
        tbl[2] = '{w: 1'b0, sz: 2'b01, se: 1'b1, addr: 9'h040, wd: 32'h0};
        for (int i = 0; i < 3; i++) begin
            do_req(tbl[i].w, tbl[i].sz, tbl[i].se, tbl[i].addr, tbl[i].wd, rd, er, lat, en, rva);
            e = sb_a.pop_front();
            checks++;
            if ({rd, er} !== {e.rdata, e.err}) begin
                errors++;
                $display("FAIL half[%0d] data: got rdata=%h err=%b, exp rdata=%h err=%b", i, rd, er, e.rdata, e.err);
            end
            checks++;
            if (lat !== e.lat || en !== e.en || rva !== 1'b0) begin
                errors++;
                $display("FAIL half[%0d] timing: got lat=%0d en=%b next=%b, exp lat=%0d en=%b next=0", i, lat, en, rva, e.lat, e.en);
            end
        end
    endtask

    task automatic test_misalign();
        req_t tbl [5];
        logic [31:0] rd;
        logic er, en, rva;
        logic [7:0] lat;
        exp_t e;
        tbl[0] = '{w: 1'b1, sz: 2'b10, se: 1'b0, addr: 9'h000, wd: 32'h55667788};
        tbl[1] = '{w: 1'b1, sz: 2'b01, se: 1'b0, addr: 9'h003, wd: 32'h0000AAAA};
        tbl[2] = '{w: 1'b0, sz: 2'b10, se: 1'b0, addr: 9'h102, wd: 32'h0};
        tbl[3] = '{w: 1'b0, sz: 2'b11, se: 1'b0, addr: 9'h010, wd: 32'h0};
        tbl[4] = '{w: 1'b0, sz: 2'b10, se: 1'b0, addr: 9'h000, wd: 32'h0};
        for (int i = 0; i < 5; i++) begin
            do_req(tbl[i].w, tbl[i].sz, tbl[i].se, tbl[i].addr, tbl[i].wd, rd, er, lat, en, rva);
            e = sb_a.pop_front();
            checks++;
            if ({rd, er} !== {e.rdata, e.err}) begin
                errors++;
                $display("FAIL misalign[%0d] data: got rdata=%h err=%b, exp rdata=%h err=%b", i, rd, er, e.rdata, e.err);
            end
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL misalign[%0d] latency: got %0d, exp %0d", i, lat, e.lat);
            end
            checks++;
            if (en !== e.en || rva !== 1'b0) begin
                errors++;
                $display("FAIL misalign[%0d] enable/pulse: got en=%b next=%b, exp en=%b next=0", i, en, rva, e.en);
            end
        end
    endtask

    // Continuous req_valid on the long-window instance: store then load.
    task automatic test_busy();
        logic [KMAX:1] en_v, rv_v, rdy_v, exp_en, exp_rv, exp_rdy;
        logic addr_ok, rw_ok;
        exp_t e;
        addr_ok = 1'b1;
        rw_ok   = 1'b1;
        for (int k = 1; k <= KMAX; k++) begin
            exp_en[k]  = (k <= W_B + 1) || ((k >= W_B + 4) && (k <= 2 * W_B + 4));
            exp_rv[k]  = (k == W_B + 2) || (k == 2 * W_B + 5);
            exp_rdy[k] = (k == W_B + 3) || (k >= 2 * W_B + 6);
        end
        sb_b.push_back('{rdata: 32'h0, err: 1'b0, en: 1'b1, lat: 8'(W_B + 2)});
        sb_b.push_back('{rdata: 32'h11223344, err: 1'b0, en: 1'b1, lat: 8'(W_B + 2)});

        @(negedge clk);
        b_req_valid = 1'b1;
        b_req_write = 1'b1;
        b_req_size  = 2'b10;
        b_req_se    = 1'b0;
        b_req_addr  = 9'h080;
        b_req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        b_req_write = 1'b0;
        b_req_addr  = 9'h084;
        b_req_wdata = 32'h0;
        for (int k = 1; k <= KMAX; k++) begin
            en_v[k]  = b_ram_enable;
            rv_v[k]  = b_resp_valid;
            rdy_v[k] = b_req_ready;
            if (b_ram_enable && (b_ram_addr !== ((k <= W_B + 1) ? 9'h080 : 9'h084))) addr_ok = 1'b0;
            if ((k <= W_B + 1) && (b_ram_rw !== 1'b1)) rw_ok = 1'b0;
            if ((k >= W_B + 4) && (b_ram_rw !== 1'b0)) rw_ok = 1'b0;
            if (b_resp_valid && sb_b.size() != 0) begin
                e = sb_b.pop_front();
                checks++;
                if ({b_resp_rdata, b_resp_err} !== {e.rdata, e.err}) begin
                    errors++;
                    $display("FAIL busy_resp@%0d: got rdata=%h err=%b, exp rdata=%h err=%b", k, b_resp_rdata, b_resp_err, e.rdata, e.err);
                end
            end
            if (k == W_B + 4) b_req_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if (en_v !== exp_en) begin
            errors++;
            $display("FAIL busy_enable: got %b, exp %b", en_v, exp_en);
        end
        checks++;
        if (rv_v !== exp_rv) begin
            errors++;
            $display("FAIL busy_resp_valid: got %b, exp %b", rv_v, exp_rv);
        end
        checks++;
        if (rdy_v !== exp_rdy) begin
            errors++;
            $display("FAIL busy_ready: got %b, exp %b", rdy_v, exp_rdy);
        end
        checks++;
        if (addr_ok !== 1'b1 || rw_ok !== 1'b1) begin
            errors++;
            $display("FAIL busy_window: got addr_stable=%b rw_ok=%b, exp 1 1", addr_ok, rw_ok);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        mem_init    = 1'b1;
        a_req_valid = 1'b0;
        a_req_write = 1'b0;
        a_req_size  = 2'b00;
        a_req_se    = 1'b0;
        a_req_addr  = '0;
        a_req_wdata = '0;
        b_req_valid = 1'b0;
        b_req_write = 1'b0;
        b_req_size  = 2'b00;
        b_req_se    = 1'b0;
        b_req_addr  = '0;
        b_req_wdata = '0;
        for (int i = 0; i < 512; i++) exp_mem[i] = 8'h00;

        test_reset();
        test_word_roundtrip();
        test_byte_sign_ext();
        test_halfword_lanes();
        test_misalign();
        test_busy();

        checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got pending a=%0d b=%0d, exp 0 0", sb_a.size(), sb_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
